// File: rtl/led_pkg.sv
`default_nettype none
// =====================================================================
// led_pkg: shared constants, scan state type and LED index helper for
//          the multiplexed LED matrix scanner.
// Revision: 1.0
// =====================================================================
package led_pkg;

  localparam int LED_ROWS       = 3;
  localparam int LED_COLS       = 4;
  localparam int LED_COUNT      = LED_ROWS * LED_COLS;
  localparam int ROW_CYCLES_DEF = 12000;
  localparam int ROW_CNT_W      = $clog2(ROW_CYCLES_DEF);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Pattern bit of the LED at (row, col); row-major with 'cols' LEDs per row.
  function automatic int led_idx(input int row, input int col, input int cols = LED_COLS);
    return row * cols + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_scan_if.sv
`default_nettype none
// =====================================================================
// led_matrix_scan_if: pattern/brightness in, matrix pins and frame pulse
//                     out. The scanner uses the slave modport.
// Revision: 1.0
// =====================================================================
interface led_matrix_scan_if #(
  parameter int ROWS     = 3,
  parameter int COLS     = 4,
  parameter int PWM_BITS = 4
);

  logic [ROWS*COLS-1:0] pattern;
  logic [PWM_BITS-1:0]  brightness;
  logic [ROWS-1:0]      row_n;
  logic [COLS-1:0]      col;
  logic                 frame_start;

  modport master (
    output pattern, brightness,
    input  row_n, col, frame_start
  );

  modport slave (
    input  pattern, brightness,
    output row_n, col, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/led_pwm_cmp.sv
`default_nettype none
// =====================================================================
// led_pwm_cmp: PWM comparator, enable while phase is below the duty.
// Revision: 1.0
// =====================================================================
module led_pwm_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] phase,
  input  logic [W-1:0] duty,
  output logic         en
);

  assign en = (phase < duty);

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan.sv
`default_nettype none
// =====================================================================
// led_matrix_scan: row-multiplexed LED matrix scanner with row blanking,
//                  PWM brightness and a per-frame input snapshot.
//                  Option macro: LED_SCAN_FADE_EN (one-frame afterglow).
// Revision: 1.0
// =====================================================================
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int ROWS         = LED_ROWS,
  parameter int COLS         = LED_COLS,
  parameter int ROW_CYCLES   = ROW_CYCLES_DEF,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  led_matrix_scan_if.slave bus
);

  localparam int NLED  = ROWS * COLS;
  localparam int CNT_W = $clog2(ROW_CYCLES);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  scan_state_t         state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [NLED-1:0]     pat_q, pat_nxt;
  logic [PWM_BITS-1:0] bri_q, bri_nxt;
  logic                capture;

  logic [ROWS-1:0]     row_n_q, row_n_nxt;
  logic [COLS-1:0]     col_q, col_nxt;
  logic                frame_start_q;

  logic [PWM_BITS-1:0] ph_nxt;
  logic [COLS-1:0]     col_en;

  // Everything is computed for the upcoming cycle so the pins line up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BLANK;
      cnt           <= '0;
      row           <= '0;
      pat_q         <= '1;
      bri_q         <= '0;
      row_n_q       <= '1;
      col_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      row           <= row_nxt;
      pat_q         <= pat_nxt;
      bri_q         <= bri_nxt;
      row_n_q       <= row_n_nxt;
      col_q         <= col_nxt;
      frame_start_q <= capture;
    end
  end

  always_comb begin
    capture = (row == ROW_LAST) && (cnt == CNT_LAST);
    cnt_nxt = cnt + 1'b1;
    row_nxt = row;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
    end
    pat_nxt   = capture ? bus.pattern    : pat_q;
    bri_nxt   = capture ? bus.brightness : bri_q;
    state_nxt = state;
    unique case (state)
      BLANK: if (cnt_nxt == CNT_BLANK) state_nxt = DRIVE;
      DRIVE: if (cnt == CNT_LAST)      state_nxt = BLANK;
    endcase
  end

  assign ph_nxt = PWM_BITS'(cnt_nxt - CNT_BLANK);

`ifdef LED_SCAN_FADE_EN
  logic [NLED-1:0] prev_q, prev_nxt;

  assign prev_nxt = capture ? pat_q : prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '1;
    else        prev_q <= prev_nxt;
  end
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS-1:0]     lit_rows;
    logic [PWM_BITS-1:0] duty;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign lit_rows[r] = ~pat_nxt[led_idx(r, c, COLS)];
    end

`ifdef LED_SCAN_FADE_EN
    logic [ROWS-1:0] fade_rows;

    for (genvar r = 0; r < ROWS; r++) begin : g_fade
      assign fade_rows[r] = ~prev_nxt[led_idx(r, c, COLS)] & pat_nxt[led_idx(r, c, COLS)];
    end

    // An LED that just went dark glows at half duty for one frame.
    assign duty = lit_rows[row_nxt]  ? bri_nxt :
                  fade_rows[row_nxt] ? (bri_nxt >> 1) : '0;
`else
    assign duty = lit_rows[row_nxt] ? bri_nxt : '0;
`endif

    led_pwm_cmp #(
      .W (PWM_BITS)
    ) u_cmp (
      .phase (ph_nxt),
      .duty  (duty),
      .en    (col_en[c])
    );
  end

  always_comb begin
    row_n_nxt = '1;
    col_nxt   = '0;
    if (state_nxt == DRIVE) begin
      row_n_nxt = ~(ROWS'(1) << row_nxt);
      col_nxt   = col_en;
    end
  end

  assign bus.row_n       = row_n_q;
  assign bus.col         = col_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// =====================================================================
// tb_led_matrix_scan: table vectors, directed corner sequences and random
//                     input changes checked against a frame-level model.
// Revision: 1.0
// =====================================================================
module tb_led_matrix_scan;

  localparam int RC    = 40;
  localparam int BC    = 4;
  localparam int FRAME = 3 * RC;
  localparam int MAXF  = 64;

  logic clk;
  logic rst_n;

  led_matrix_scan_if #(.ROWS(3), .COLS(4), .PWM_BITS(4)) bus ();

  led_matrix_scan #(
    .ROWS         (3),
    .COLS         (4),
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC),
    .PWM_BITS     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int on_acc    = 0;
  int blank_acc = 0;

  logic [11:0] cap_pat [MAXF];
  logic [3:0]  cap_bri [MAXF];

  typedef struct {
    logic [11:0] pat;
    logic [3:0]  bri;
    int          exp_on;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected {row_n, col, frame_start} at cycle tt after reset release.
  function automatic logic [7:0] model(input int tt);
    int          cnt = tt % RC;
    int          row = (tt / RC) % 3;
    int          f   = tt / FRAME;
    int          ph;
    logic [11:0] p   = 12'hFFF;
    logic [11:0] pv  = 12'hFFF;
    int          b   = 0;
    logic [2:0]  rn  = 3'b111;
    logic [3:0]  cl  = 4'b0000;
    logic [3:0]  idx;
    logic        fs  = (tt > 0) && (tt % FRAME == 0);
    if (f >= 1 && f < MAXF) begin
      p = cap_pat[f];
      b = int'(cap_bri[f]);
    end
    if (f >= 2 && f < MAXF) pv = cap_pat[f-1];
    if (cnt >= BC) begin
      rn = ~(3'b001 << row);
      ph = (cnt - BC) % 16;
      for (int cc = 0; cc < 4; cc++) begin
        idx = 4'(row * 4 + cc);
        if (!p[idx] && ph < b) cl[cc] = 1'b1;
`ifdef LED_SCAN_FADE_EN
        if (p[idx] && !pv[idx] && ph < b / 2) cl[cc] = 1'b1;
`endif
      end
    end
    return {rn, cl, fs};
  endfunction

  // Called at a negedge with this cycle's inputs already applied.
  task automatic tick();
    logic [7:0] e = model(t);
    int         f = t / FRAME + 1;
    chk($sformatf("cycle t=%0d {row_n,col,fs}", t),
        32'({bus.row_n, bus.col, bus.frame_start}), 32'(e));
    chk($sformatf("row_onehot t=%0d", t), 32'($countones(~bus.row_n) <= 1), 32'd1);
    on_acc += $countones(bus.col);
    if (bus.row_n == 3'b111) blank_acc++;
    if (t % FRAME == FRAME - 1 && f < MAXF) begin
      cap_pat[f] = bus.pattern;
      cap_bri[f] = bus.brightness;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic run_to_frame();
    while (t % FRAME != 0) tick();
  endtask

  // Entered at a negedge; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({bus.row_n, bus.col, bus.frame_start}), 32'({3'b111, 4'b0000, 1'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rseq [3];
    int         first_fs;
    int         exp_on6;
    logic [3:0] exp_ph6;

    rseq[0] = 3'b110;
    rseq[1] = 3'b101;
    rseq[2] = 3'b011;
    vecs[0] = '{pat: 12'hFFE, bri: 4'd15, exp_on: 34};
    vecs[1] = '{pat: 12'hFFF, bri: 4'd15, exp_on: 0};
    vecs[2] = '{pat: 12'h000, bri: 4'd4,  exp_on: 144};
    vecs[3] = '{pat: 12'h000, bri: 4'd0,  exp_on: 0};
    vecs[4] = '{pat: 12'h0F0, bri: 4'd8,  exp_on: 160};
    vecs[5] = '{pat: 12'h7FF, bri: 4'd1,  exp_on: 3};

    bus.pattern    = 12'hFFE;
    bus.brightness = 4'd15;
    rst_n          = 1'b1;
    @(negedge clk);
    do_reset();

    // First frame dark, then LED 0 lit except at ph 15.
    first_fs = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus.frame_start && first_fs < 0) first_fs = t;
      if (t == 50)  chk("t1_first_frame_dark", 32'(bus.col), 32'h0);
      if (t == 124) chk("t1_ph0_col",          32'(bus.col), 32'h1);
      if (t == 139) chk("t1_ph15_col",         32'(bus.col), 32'h0);
      tick();
    end
    chk("t1_first_frame_start", 32'(first_fs), 32'd120);

    // All-off pattern: rows still scan, each slot blanks for exactly BC cycles.
    bus.pattern = 12'hFFF;
    run_to_frame();
    for (int s = 0; s < 3; s++) begin
      blank_acc = 0;
      on_acc    = 0;
      for (int k = 0; k < RC; k++) begin
        if (k == BC) chk($sformatf("t2_row_n slot%0d", s), 32'(bus.row_n), 32'(rseq[s]));
        tick();
      end
      chk($sformatf("t3_blank_len slot%0d", s), 32'(blank_acc), 32'(BC));
      chk($sformatf("t2_col_dark slot%0d", s),  32'(on_acc), 32'd0);
    end

    // Table vectors: lit (cycle, column) pairs over a settled frame.
    for (int v = 0; v < 6; v++) begin
      run_to_frame();
      bus.pattern    = vecs[v].pat;
      bus.brightness = vecs[v].bri;
      repeat (2 * FRAME) tick();
      on_acc = 0;
      repeat (FRAME) tick();
      chk($sformatf("vec%0d_on_count", v), 32'(on_acc), 32'(vecs[v].exp_on));
    end

    // Mid-frame pattern change must not tear the current frame.
    run_to_frame();
    bus.pattern    = 12'hFFE;
    bus.brightness = 4'd15;
    repeat (FRAME) tick();
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k == 50)  bus.pattern = 12'hFDF;
      if (k == 60)  chk("t5_no_tear",  32'(bus.col), 32'h0);
      if (k == 164) chk("t5_led5_lit", 32'(bus.col), 32'h2);
      tick();
    end

    // Random input changes at arbitrary cycles.
    for (int k = 0; k < 8 * FRAME; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        bus.pattern    = 12'($urandom());
        bus.brightness = 4'($urandom());
      end
      tick();
    end

    // Asynchronous reset at row 2 cnt 20, then restart and afterglow step.
    run_to_frame();
    bus.pattern    = 12'hFFE;
    bus.brightness = 4'd15;
    repeat (100) tick();
    do_reset();
    chk("t6_restart_blank", 32'({bus.row_n, bus.col}), 32'({3'b111, 4'b0000}));
    repeat (FRAME) tick();
    bus.pattern = 12'hFFD;
    repeat (FRAME) tick();
`ifdef LED_SCAN_FADE_EN
    exp_on6 = 52;
    exp_ph6 = 4'b0011;
`else
    exp_on6 = 34;
    exp_ph6 = 4'b0010;
`endif
    on_acc = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 10) chk("t6_ph6_col", 32'(bus.col), 32'(exp_ph6));
      tick();
    end
    chk("t6_frame_on_count", 32'(on_acc), 32'(exp_on6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
